// File: rtl/pdm_mic_emulator_pkg.sv
// Shared constants and helpers for the PDM microphone emulator.
// Channel numbering: line k carries channel 2k (left) and 2k+1 (right).
package pdm_emu_pkg;

    localparam int PCM_W = 16;
    localparam int ACC_W = 16;
    localparam logic [ACC_W-1:0] OFFSET = 16'h8000;

    typedef enum logic {
        LR_LEFT  = 1'b0,
        LR_RIGHT = 1'b1
    } lr_e;

    function automatic int ch_of(input int line, input logic lr);
        return 2 * line + int'(lr);
    endfunction

endpackage

// File: rtl/pdm_mic_emulator_if.sv
// PCM write port of the emulator: the host loads one sample per transfer.
// A transfer happens on every clk edge where pcm_valid and pcm_ready are both 1;
// the master holds channel/data stable while valid is high and not yet accepted.
interface pdm_mic_emulator_if #(
    parameter int CH_W  = 3,
    parameter int PCM_W = 16
) ();

    logic             pcm_valid;
    logic             pcm_ready;
    logic [CH_W-1:0]  pcm_channel;
    logic [PCM_W-1:0] pcm_data;

    modport master (
        output pcm_valid,
        output pcm_channel,
        output pcm_data,
        input  pcm_ready
    );

    modport slave (
        input  pcm_valid,
        input  pcm_channel,
        input  pcm_data,
        output pcm_ready
    );

endinterface

// File: rtl/pdm_mic_emulator_sd_mod.sv
// First-order sigma-delta modulator for one channel: the carry out of an
// offset-binary accumulator is the PDM bit, so ones density = u / 2^16.
module pdm_sd_mod
    import pdm_emu_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             step,
    input  logic [ACC_W-1:0] sample,
    output logic             bit_out
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, sample ^ OFFSET};
    assign bit_out = sum[ACC_W];

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pdm_mic_emulator.sv
// PDM microphone array emulator: follows the collector's mic_clock/mic_select
// and drives one modulated bit per line on every served mic_clock edge.
module pdm_mic_emulator #(
    parameter int NUM_LINES = 4,
    parameter int PCM_W     = 16,
    parameter int CH_W      = $clog2(2 * NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mic_clock,
    input  logic                 mic_select,
    input  logic                 enable,
    pdm_mic_emulator_if.slave    pcm,
    output logic [NUM_LINES-1:0] mic_data,
    output logic [31:0]          edge_count
);

    import pdm_emu_pkg::*;

    localparam int NUM_CH = 2 * NUM_LINES;
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [2:0]           mclk_q;
    logic [1:0]           msel_q;
    logic                 ready_q;
    logic [NUM_LINES-1:0] mic_q;
    logic [NUM_LINES-1:0] mic_d;
    logic [31:0]          cnt_q;
    logic [31:0]          cnt_d;
    logic [PCM_W-1:0]     pend_q [NUM_CH];
    logic [PCM_W-1:0]     act_q  [NUM_CH];

    logic              rise;
    logic              fall;
    logic              served;
    lr_e               lr;
    logic              wr_hit;
    logic              clr;
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] mod_bit;

    // mclk_q[1] is the synchronised level, mclk_q[2] its one-cycle-old copy.
    assign rise   = mclk_q[1] & ~mclk_q[2];
    assign fall   = ~mclk_q[1] & mclk_q[2];
    assign served = enable & (rise | fall);
    assign lr     = rise ? lr_e'(msel_q[1]) : lr_e'(~msel_q[1]);
    assign wr_hit = pcm.pcm_valid & ready_q & ({1'b0, pcm.pcm_channel} < NUM_CH_V);
    assign clr    = ~enable;

    assign pcm.pcm_ready = ready_q;
    assign mic_data      = mic_q;
    assign edge_count    = cnt_q;

    always_comb begin
        step = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            step[c] = served & (lr == (((c % 2) == 1) ? LR_RIGHT : LR_LEFT));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_mod
        pdm_sd_mod u_mod (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr),
            .step    (step[c]),
            .sample  (act_q[c]),
            .bit_out (mod_bit[c])
        );
    end

    always_comb begin
        mic_d = mic_q;
        if (!enable) begin
            mic_d = '0;
        end else if (served) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                mic_d[k] = mod_bit[ch_of(k, lr)];
            end
        end
        cnt_d = cnt_q + {31'b0, enable & rise};
    end

    // Commit reads pending before this cycle's write lands, so a same-cycle
    // write is picked up by the next served edge of that channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mclk_q  <= '0;
            msel_q  <= '0;
            ready_q <= 1'b0;
            mic_q   <= '0;
            cnt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_q[c] <= '0;
                act_q[c]  <= '0;
            end
        end else begin
            mclk_q  <= {mclk_q[1:0], mic_clock};
            msel_q  <= {msel_q[0], mic_select};
            ready_q <= 1'b1;
            mic_q   <= mic_d;
            cnt_q   <= cnt_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (step[c]) begin
                    act_q[c] <= pend_q[c];
                end
                if (wr_hit && (pcm.pcm_channel == CH_W'(c))) begin
                    pend_q[c] <= pcm.pcm_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Bench for pdm_mic_emulator: a per-edge behavioural model of the PDM stream
// is compared every cycle, plus hand-derived bit patterns for key scenarios.
module tb_pdm_mic_emulator;

    localparam int NL  = 3;
    localparam int NCH = 2 * NL;
    localparam int CHW = 3;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          mic_clock  = 1'b0;
    logic          mic_select = 1'b0;
    logic          enable     = 1'b0;
    logic [NL-1:0] mic_data;
    logic [31:0]   edge_count;

    pdm_mic_emulator_if #(.CH_W(CHW), .PCM_W(16)) pcm_if ();

    pdm_mic_emulator #(.NUM_LINES(NL), .PCM_W(16), .CH_W(CHW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mic_clock  (mic_clock),
        .mic_select (mic_select),
        .enable     (enable),
        .pcm        (pcm_if),
        .mic_data   (mic_data),
        .edge_count (edge_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each pin edge of mic_clock becomes an event that takes effect on the
    // third clk edge after it; at that point every line emits the bit of the
    // channel the edge serves and that channel's pending sample is committed.
    typedef struct packed {
        int   due;
        logic lr;
        logic rise;
    } ev_t;

    ev_t          evq[$];
    logic [15:0]  m_pend [NCH];
    logic [15:0]  m_act  [NCH];
    int unsigned  m_acc  [NCH];
    logic [NL-1:0] exp_mic;
    logic [31:0]  exp_cnt;
    logic         exp_ready;
    logic         m_prev;
    int           m_cyc;

    always @(posedge clk or negedge reset_n) begin
        ev_t         e;
        int          c;
        int unsigned u;
        int unsigned tot;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = '0;
                m_act[i]  = '0;
                m_acc[i]  = 0;
            end
            exp_mic   = '0;
            exp_cnt   = '0;
            exp_ready = 1'b0;
            m_prev    = 1'b0;
            m_cyc     = 0;
            evq.delete();
        end else begin
            m_cyc++;
            if (mic_clock !== m_prev) begin
                e.due  = m_cyc + 2;
                e.rise = mic_clock;
                e.lr   = mic_clock ? mic_select : ~mic_select;
                evq.push_back(e);
                m_prev = mic_clock;
            end
            if (!enable) begin
                for (int i = 0; i < NCH; i++) m_acc[i] = 0;
                exp_mic = '0;
                while (evq.size() > 0 && evq[0].due <= m_cyc) e = evq.pop_front();
            end else if (evq.size() > 0 && evq[0].due <= m_cyc) begin
                e = evq.pop_front();
                for (int k = 0; k < NL; k++) begin
                    c          = 2 * k + int'(e.lr);
                    u          = 32'(m_act[c] ^ 16'h8000);
                    tot        = m_acc[c] + u;
                    exp_mic[k] = (tot >= 65536);
                    m_acc[c]   = tot % 65536;
                    m_act[c]   = m_pend[c];
                end
                if (e.rise) exp_cnt = exp_cnt + 1;
            end
            if (pcm_if.pcm_valid && exp_ready && int'(pcm_if.pcm_channel) < NCH)
                m_pend[pcm_if.pcm_channel] = pcm_if.pcm_data;
            exp_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("mic_data", 32'(mic_data), 32'(exp_mic));
        check("edge_count", edge_count, exp_cnt);
        check("pcm_ready", 32'(pcm_if.pcm_ready), 32'(exp_ready));
    end

    // ---------------- driver tasks ----------------
    // Toggle mic_clock at a falling clk edge; report mic_data two and three
    // clk cycles later, then finish out a half-period of h cycles.
    task automatic pin_edge(input int h, output logic [NL-1:0] early, output logic [NL-1:0] obs);
        mic_clock = ~mic_clock;
        repeat (2) @(negedge clk);
        early = mic_data;
        @(negedge clk);
        obs = mic_data;
        repeat (h - 3) @(negedge clk);
    endtask

    task automatic write_pcm(input int ch, input logic [15:0] d);
        pcm_if.pcm_valid   = 1'b1;
        pcm_if.pcm_channel = CHW'(ch);
        pcm_if.pcm_data    = d;
        @(negedge clk);
        pcm_if.pcm_valid   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NL-1:0] early;
        logic [NL-1:0] obs;
        int            h;

        pcm_if.pcm_valid   = 1'b0;
        pcm_if.pcm_channel = '0;
        pcm_if.pcm_data    = '0;

        // Reset held while mic_clock toggles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mic_clock = ~mic_clock;
            check("rst_mic_data", 32'(mic_data), 32'h0);
            check("rst_pcm_ready", 32'(pcm_if.pcm_ready), 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        check("ready_at_release", 32'(pcm_if.pcm_ready), 32'h0);
        @(negedge clk);
        check("ready_after_release", 32'(pcm_if.pcm_ready), 32'h1);

        // mic_select=0: ch0=0x0000 alternates, ch1=0x7FFF goes to ones, ch3=0x8000 stays zero.
        write_pcm(0, 16'h0000);
        write_pcm(1, 16'h7FFF);
        write_pcm(3, 16'h8000);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pin_edge(8, early, obs);
            check("A_rise_line0", 32'(obs[0]), 32'(i % 2));
            pin_edge(8, early, obs);
            check("A_fall_line0", 32'(obs[0]), (i == 0) ? 32'h0 : 32'h1);
            check("A_fall_line1", 32'(obs[1]), 32'h0);
        end
        check("A_edge_count", edge_count, 32'd16);

        // mic_select=1: falls serve L (ones), rises serve R (zeros); 3-cycle latency.
        write_pcm(0, 16'h7FFF);
        write_pcm(1, 16'h8000);
        mic_select = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pin_edge(8, early, obs);
            if (i >= 4) check("B_rise_R", 32'(obs[0]), 32'h0);
            pin_edge(8, early, obs);
            if (i >= 4) begin
                check("B_fall_before_latency", 32'(early[0]), 32'h0);
                check("B_fall_L", 32'(obs[0]), 32'h1);
            end
        end

        // Write to ch0 in the very cycle its commit happens.
        mic_select = 1'b0;
        mic_clock  = 1'b1;
        repeat (2) @(negedge clk);
        pcm_if.pcm_valid   = 1'b1;
        pcm_if.pcm_channel = 3'd0;
        pcm_if.pcm_data    = 16'h8000;
        @(negedge clk);
        pcm_if.pcm_valid = 1'b0;
        obs = mic_data;
        repeat (5) @(negedge clk);
        check("C_commit_rise0", 32'(obs[0]), 32'h1);
        pin_edge(8, early, obs);
        pin_edge(8, early, obs);
        check("C_commit_rise1", 32'(obs[0]), 32'h1);
        pin_edge(8, early, obs);
        pin_edge(8, early, obs);
        check("C_commit_rise2", 32'(obs[0]), 32'h0);
        pin_edge(8, early, obs);
        write_pcm(7, 16'h1234);
        write_pcm(6, 16'hABCD);

        // Enable low for 10 edges, then a clean restart.
        write_pcm(0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            pin_edge(8, early, obs);
            pin_edge(8, early, obs);
        end
        check("D_count_before", edge_count, 32'd33);
        enable = 1'b0;
        write_pcm(2, 16'h4000);
        for (int i = 0; i < 10; i++) begin
            pin_edge(8, early, obs);
            check("D_off_mic_data", 32'(obs), 32'h0);
            check("D_off_edge_count", edge_count, 32'd33);
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pin_edge(8, early, obs);
            check("D_restart_rise", 32'(obs[0]), 32'(i % 2));
            pin_edge(8, early, obs);
        end
        check("D_count_after", edge_count, 32'd37);

        // Randomised traffic: edge spacing, select, enable and writes.
        for (int i = 0; i < 600; i++) begin
            h = $urandom_range(4, 12);
            if ($urandom_range(0, 3) == 0) mic_select = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            mic_clock = ~mic_clock;
            for (int j = 0; j < h; j++) begin
                pcm_if.pcm_valid   = ($urandom_range(0, 2) == 0);
                pcm_if.pcm_channel = CHW'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       pcm_if.pcm_data = 16'h7FFF;
                    1:       pcm_if.pcm_data = 16'h8000;
                    default: pcm_if.pcm_data = 16'($urandom);
                endcase
                @(negedge clk);
            end
            pcm_if.pcm_valid = 1'b0;
        end
        enable = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
